// File: rtl/eth_mon_pkg.sv
// Shared definitions for the AXI4-Stream rate monitor: FSM states, tkeep helpers
// and the default window length.
package eth_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_HOLD  = 2'd3
    } mon_state_t;

    // One second of RUN cycles at 156.25 MHz.
    localparam int DEFAULT_WINDOW_CYCLES = 156250000;

    // Helpers take tkeep zero-extended to this width (covers data paths up to 1024 bits).
    localparam int MAX_KEEP_W = 128;
    localparam int POP_W      = 8;

    function automatic logic [POP_W-1:0] popcount(input logic [MAX_KEEP_W-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_KEEP_W; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

    // True for 2^k-1 patterns, including all-zero.
    function automatic logic keep_contig(input logic [MAX_KEEP_W-1:0] v);
        return (v & (v + MAX_KEEP_W'(1))) == '0;
    endfunction

endpackage

// File: rtl/eth_sat_counter.sv
// Saturating accumulator: adds addend when enabled, sticks at all-ones and flags overflow.
// load starts a fresh sum from the current addend instead of adding to the old count.
module eth_sat_counter #(
    parameter int CNT_W = 48,
    parameter int ADD_W = 4
) (
    input  logic             coreclk_out,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [ADD_W-1:0] addend,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    logic [CNT_W:0] base;
    logic [CNT_W:0] raw;
    logic           carry;

    assign base  = load ? '0 : {1'b0, count};
    assign raw   = base + (CNT_W+1)'(addend);
    assign carry = raw[CNT_W];

    always_ff @(posedge coreclk_out) begin
        if (reset || clr) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (en) begin
            count <= carry ? '1 : raw[CNT_W-1:0];
            if (carry) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_axis_rate_monitor.sv
// Passive multi-channel AXI4-Stream byte/cycle rate monitor with windowed snapshots.
// Define RATE_MON_PEAK_EN to add the per-channel peak window output.
module eth_axis_rate_monitor
    import eth_mon_pkg::*;
#(
    parameter int DATA_W        = 64,
    parameter int NUM_CH        = 2,
    parameter int CNT_W         = 48,
    parameter int WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES
) (
    input  logic                         coreclk_out,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            mon_tvalid,
    input  logic [NUM_CH-1:0]            mon_tready,
    input  logic [NUM_CH*(DATA_W/8)-1:0] mon_tkeep,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         clear,
    output logic [1:0]                   state_out,
    output logic [NUM_CH*CNT_W-1:0]      total_bytes,
    output logic [CNT_W-1:0]             total_cycles,
    output logic [NUM_CH*CNT_W-1:0]      win_bytes,
    output logic                         win_valid,
    output logic [NUM_CH-1:0]            keep_err,
    output logic [NUM_CH:0]              ovf
`ifdef RATE_MON_PEAK_EN
    ,
    output logic [NUM_CH*CNT_W-1:0]      peak_win_bytes
`endif
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int ADD_W  = $clog2(KEEP_W + 1);
    localparam int WC_W   = $clog2(WINDOW_CYCLES);
    localparam logic [WC_W-1:0] WIN_LAST = WC_W'(WINDOW_CYCLES - 1);

    mon_state_t      state;
    mon_state_t      state_next;
    logic            any_beat;
    logic            gate;
    logic            s1_run;
    logic [WC_W-1:0] win_pos;
    logic            win_load;
    logic            win_close;
    logic            cyc_ovf;

    // A beat is tvalid & tready on the snooped stream; the monitor never drives either.
    assign any_beat = |(mon_tvalid & mon_tready);
    // Stage-1 gate: RUN, or the ARMED cycle that carries the first beat.
    assign gate     = (state == ST_RUN) || (state == ST_ARMED && any_beat && !stop);

    always_ff @(posedge coreclk_out) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start && !stop)    state_next = ST_ARMED;
                ST_ARMED: if (any_beat && !stop) state_next = ST_RUN;
                ST_RUN:   if (stop)              state_next = ST_HOLD;
                ST_HOLD:  if (start && !stop)    state_next = ST_ARMED;
                default:                         state_next = ST_IDLE;
            endcase
        end
    end

    assign state_out = state;

    assign win_load  = (win_pos == '0);
    assign win_close = s1_run && (win_pos == WIN_LAST);

    always_ff @(posedge coreclk_out) begin
        if (reset || clear) begin
            s1_run    <= 1'b0;
            win_pos   <= '0;
            win_valid <= 1'b0;
        end else begin
            s1_run    <= gate;
            win_valid <= win_close;
            if (s1_run) begin
                win_pos <= win_close ? '0 : win_pos + WC_W'(1);
            end
        end
    end

    eth_sat_counter #(.CNT_W(CNT_W), .ADD_W(1)) u_cyc_cnt (
        .coreclk_out (coreclk_out),
        .reset       (reset),
        .clr         (clear),
        .en          (s1_run),
        .load        (1'b0),
        .addend      (1'b1),
        .count       (total_cycles),
        .ovf         (cyc_ovf)
    );

    assign ovf[NUM_CH] = cyc_ovf;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [MAX_KEEP_W-1:0] keep_ext;
        logic                  beat;
        logic [ADD_W-1:0]      s1_add;
        logic                  s1_kerr;
        logic                  kerr_q;
        logic [CNT_W-1:0]      tot;
        logic [CNT_W-1:0]      acc;
        logic [CNT_W-1:0]      win_q;
        logic                  tot_ovf;
        logic                  win_ovf;

        always_comb begin
            keep_ext             = '0;
            keep_ext[KEEP_W-1:0] = mon_tkeep[c*KEEP_W +: KEEP_W];
        end

        assign beat = gate & mon_tvalid[c] & mon_tready[c];

        always_ff @(posedge coreclk_out) begin
            if (reset || clear) begin
                s1_add  <= '0;
                s1_kerr <= 1'b0;
                kerr_q  <= 1'b0;
                win_q   <= '0;
            end else begin
                s1_add  <= beat ? ADD_W'(popcount(keep_ext)) : '0;
                s1_kerr <= beat && !keep_contig(keep_ext);
                kerr_q  <= kerr_q | s1_kerr;
                if (win_valid) begin
                    win_q <= acc;
                end
            end
        end

        eth_sat_counter #(.CNT_W(CNT_W), .ADD_W(ADD_W)) u_tot_cnt (
            .coreclk_out (coreclk_out),
            .reset       (reset),
            .clr         (clear),
            .en          (s1_run),
            .load        (1'b0),
            .addend      (s1_add),
            .count       (tot),
            .ovf         (tot_ovf)
        );

        // The accumulator holds the finished window sum for the pulse cycle, then
        // restarts from the first addend of the next window.
        eth_sat_counter #(.CNT_W(CNT_W), .ADD_W(ADD_W)) u_win_acc (
            .coreclk_out (coreclk_out),
            .reset       (reset),
            .clr         (clear),
            .en          (s1_run),
            .load        (win_load),
            .addend      (s1_add),
            .count       (acc),
            .ovf         (win_ovf)
        );

        assign total_bytes[c*CNT_W +: CNT_W] = tot;
        assign win_bytes[c*CNT_W +: CNT_W]   = win_valid ? acc : win_q;
        assign keep_err[c]                   = kerr_q;
        assign ovf[c]                        = tot_ovf | win_ovf;

`ifdef RATE_MON_PEAK_EN
        logic [CNT_W-1:0] peak_q;
        logic [CNT_W-1:0] peak_now;

        assign peak_now = (win_valid && acc > peak_q) ? acc : peak_q;

        always_ff @(posedge coreclk_out) begin
            if (reset || clear) begin
                peak_q <= '0;
            end else begin
                peak_q <= peak_now;
            end
        end

        assign peak_win_bytes[c*CNT_W +: CNT_W] = peak_now;
`endif
    end

endmodule

// File: tb/tb_eth_axis_rate_monitor.sv
// Bench for eth_axis_rate_monitor: two instances (16-bit and 8-bit counters) on shared
// stimulus, checked each cycle against a behavioural model plus directed expectations.
module tb_eth_axis_rate_monitor;

    localparam int WIN     = 100;
    localparam int S_IDLE  = 0;
    localparam int S_ARMED = 1;
    localparam int S_RUN   = 2;
    localparam int S_HOLD  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  tvalid, tready;
    logic [15:0] tkeep;
    logic        start, stop, clear;

    logic [1:0]  st0, st1;
    logic [31:0] tot0, wb0;
    logic [15:0] tot1, wb1;
    logic [15:0] cyc0;
    logic [7:0]  cyc1;
    logic        wv0, wv1;
    logic [1:0]  ke0, ke1;
    logic [2:0]  ovf0, ovf1;
`ifdef RATE_MON_PEAK_EN
    logic [31:0] pk0;
    logic [15:0] pk1;
`endif

    int tests_run  = 0;
    int fail_count = 0;

    always #5 clk = ~clk;

    eth_axis_rate_monitor #(.DATA_W(64), .NUM_CH(2), .CNT_W(16), .WINDOW_CYCLES(WIN)) dut (
        .coreclk_out (clk), .reset (reset),
        .mon_tvalid (tvalid), .mon_tready (tready), .mon_tkeep (tkeep),
        .start (start), .stop (stop), .clear (clear),
        .state_out (st0), .total_bytes (tot0), .total_cycles (cyc0),
        .win_bytes (wb0), .win_valid (wv0), .keep_err (ke0), .ovf (ovf0)
`ifdef RATE_MON_PEAK_EN
        , .peak_win_bytes (pk0)
`endif
    );

    eth_axis_rate_monitor #(.DATA_W(64), .NUM_CH(2), .CNT_W(8), .WINDOW_CYCLES(WIN)) dut_s (
        .coreclk_out (clk), .reset (reset),
        .mon_tvalid (tvalid), .mon_tready (tready), .mon_tkeep (tkeep),
        .start (start), .stop (stop), .clear (clear),
        .state_out (st1), .total_bytes (tot1), .total_cycles (cyc1),
        .win_bytes (wb1), .win_valid (wv1), .keep_err (ke1), .ovf (ovf1)
`ifdef RATE_MON_PEAK_EN
        , .peak_win_bytes (pk1)
`endif
    );

    // Reference model: index 0 is the 16-bit instance, 1 the 8-bit one.
    longint maxv[2];
    int     m_state;
    longint m_tot[2][2], m_acc[2][2], m_win[2][2], m_cyc[2];
    int     m_pos[2];
    bit     m_wv[2];
    bit     m_kerr[2][2];
    bit     m_ovf[2][3];
    bit     p_run;
    int     p_bytes[2];
    bit     p_kerr[2];

    task automatic check(input string tag, input longint got, input longint exp);
        tests_run++;
        if (got !== exp) begin
            fail_count++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint sat_add(input int i, input longint a, input longint b,
                                       inout bit flag);
        longint s;
        s = a + b;
        if (s > maxv[i]) begin
            s    = maxv[i];
            flag = 1'b1;
        end
        return s;
    endfunction

    // Effect of one clock edge: counted cycles land in the counters two edges after
    // the beat; clear/reset drop anything still in flight.
    task automatic model_edge();
        logic [7:0] k;
        bit         any, gate, beat;
        if (reset || clear) begin
            m_state = S_IDLE;
            p_run   = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_cyc[i] = 0; m_pos[i] = 0; m_wv[i] = 1'b0;
                for (int c = 0; c < 2; c++) begin
                    m_tot[i][c] = 0; m_acc[i][c] = 0; m_win[i][c] = 0; m_kerr[i][c] = 1'b0;
                end
                for (int b = 0; b < 3; b++) m_ovf[i][b] = 1'b0;
            end
            for (int c = 0; c < 2; c++) begin
                p_bytes[c] = 0; p_kerr[c] = 1'b0;
            end
            return;
        end
        for (int i = 0; i < 2; i++) begin
            m_wv[i] = 1'b0;
            if (p_run) begin
                for (int c = 0; c < 2; c++) begin
                    m_tot[i][c] = sat_add(i, m_tot[i][c], longint'(p_bytes[c]), m_ovf[i][c]);
                    m_acc[i][c] = sat_add(i, m_acc[i][c], longint'(p_bytes[c]), m_ovf[i][c]);
                    if (p_kerr[c]) m_kerr[i][c] = 1'b1;
                end
                m_cyc[i] = sat_add(i, m_cyc[i], 1, m_ovf[i][2]);
                m_pos[i]++;
                if (m_pos[i] == WIN) begin
                    m_pos[i] = 0;
                    m_wv[i]  = 1'b1;
                    for (int c = 0; c < 2; c++) begin
                        m_win[i][c] = m_acc[i][c];
                        m_acc[i][c] = 0;
                    end
                end
            end
        end
        any   = |(tvalid & tready);
        gate  = (m_state == S_RUN) || (m_state == S_ARMED && any && !stop);
        p_run = gate;
        for (int c = 0; c < 2; c++) begin
            k          = tkeep[c*8 +: 8];
            beat       = gate && tvalid[c] && tready[c];
            p_bytes[c] = beat ? $countones(k) : 0;
            p_kerr[c]  = beat && (k != 8'h00) && ((k & (k + 8'd1)) != 8'h00);
        end
        case (m_state)
            S_IDLE:  if (start && !stop) m_state = S_ARMED;
            S_ARMED: if (any && !stop)   m_state = S_RUN;
            S_RUN:   if (stop)           m_state = S_HOLD;
            default: if (start && !stop) m_state = S_ARMED;
        endcase
    endtask

    task automatic check_all();
        check("state0", st0, m_state);
        check("state1", st1, m_state);
        check("cycles0", cyc0, m_cyc[0]);
        check("cycles1", cyc1, m_cyc[1]);
        check("win_valid0", wv0, m_wv[0]);
        check("win_valid1", wv1, m_wv[1]);
        check("ovf0", ovf0, {m_ovf[0][2], m_ovf[0][1], m_ovf[0][0]});
        check("ovf1", ovf1, {m_ovf[1][2], m_ovf[1][1], m_ovf[1][0]});
        for (int c = 0; c < 2; c++) begin
            check($sformatf("total0_ch%0d", c), tot0[c*16 +: 16], m_tot[0][c]);
            check($sformatf("total1_ch%0d", c), tot1[c*8 +: 8], m_tot[1][c]);
            check($sformatf("win0_ch%0d", c), wb0[c*16 +: 16], m_win[0][c]);
            check($sformatf("win1_ch%0d", c), wb1[c*8 +: 8], m_win[1][c]);
            check($sformatf("keep_err0_ch%0d", c), ke0[c], m_kerr[0][c]);
            check($sformatf("keep_err1_ch%0d", c), ke1[c], m_kerr[1][c]);
        end
    endtask

    // Driver tasks: inputs are set before the edge, outputs checked 1 time unit after it.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        tvalid = '0; tready = '0; tkeep = '0;
        start = 1'b0; stop = 1'b0; clear = 1'b0;
    endtask

    task automatic pulse_start(); start = 1'b1; cyc(); start = 1'b0; endtask
    task automatic pulse_stop();  stop  = 1'b1; cyc(); stop  = 1'b0; endtask
    task automatic pulse_clear(); clear = 1'b1; cyc(); clear = 1'b0; endtask

    task automatic beat0(input logic [7:0] k);
        tvalid[0] = 1'b1; tready[0] = 1'b1; tkeep[7:0] = k;
        cyc();
        tvalid[0] = 1'b0; tready[0] = 1'b0; tkeep[7:0] = 8'h00;
    endtask

    function automatic logic [7:0] rand_keep();
        int unsigned r, k;
        logic [8:0] one;
        r = $urandom_range(0, 3);
        k = $urandom_range(0, 8);
        one = 9'd1;
        case (r)
            0:       return 8'hFF;
            1:       return 8'((one << k) - 9'd1);
            2:       return 8'($urandom);
            default: return 8'hFF;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int npulse;
        maxv[0] = 65535;
        maxv[1] = 255;
        idle_inputs();
        reset = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        check("reset_state", st0, S_IDLE);
        check("reset_total", tot0, 0);

        // Steady rate: full-keep beat on ch0 every cycle.
        pulse_clear();
        pulse_start();
        tvalid[0] = 1'b1; tready = 2'b11; tkeep[7:0] = 8'hFF;
        npulse = 0;
        repeat (250) begin
            cyc();
            if (wv0) begin
                npulse++;
                check("steady_ch0", wb0[15:0], 800);
                check("steady_ch1", wb0[31:16], 0);
            end
        end
        check("steady_pulses", npulse, 2);
        idle_inputs();
        pulse_stop();
        repeat (2) cyc();

        // Partial keep.
        pulse_clear();
        pulse_start();
        beat0(8'h01);
        beat0(8'h07);
        beat0(8'hFF);
        check("partial_early", tot0[15:0], 4);
        cyc();
        check("partial_total", tot0[15:0], 12);
        check("partial_keep_err", ke0, 0);

        // Bad keep.
        pulse_clear();
        pulse_start();
        beat0(8'h05);
        repeat (2) cyc();
        check("badkeep_total", tot0[15:0], 2);
        check("badkeep_flag", ke0[0], 1);
        repeat (10) cyc();
        check("badkeep_sticky", ke0[0], 1);
        pulse_clear();
        check("badkeep_cleared", ke0[0], 0);

        // Arm / stop / resume on ch1.
        pulse_start();
        repeat (50) cyc();
        check("armed_cycles", cyc0, 0);
        check("armed_state", st0, S_ARMED);
        tvalid[1] = 1'b1; tready[1] = 1'b1; tkeep[15:8] = 8'hFF;
        cyc();
        check("run_state", st0, S_RUN);
        repeat (20) cyc();
        pulse_stop();
        check("hold_state", st0, S_HOLD);
        repeat (22) cyc();
        check("hold_total", tot0[31:16], 176);
        check("hold_cycles", cyc0, 22);
        pulse_start();
        check("resume_state", st0, S_ARMED);
        check("resume_total", tot0[31:16], 176);
        repeat (3) cyc();
        idle_inputs();
        repeat (2) cyc();

        // Saturation of the 8-bit instance.
        pulse_clear();
        pulse_start();
        tvalid[0] = 1'b1; tready[0] = 1'b1; tkeep[7:0] = 8'hFF;
        repeat (40) cyc();
        tvalid = '0;
        repeat (2) cyc();
        check("sat_total", tot1[7:0], 255);
        check("sat_ovf", ovf1[0], 1);
        check("sat_wide_total", tot0[15:0], 320);

        // clear + stop + start together while traffic runs.
        tvalid[0] = 1'b1;
        repeat (5) cyc();
        clear = 1'b1; stop = 1'b1; start = 1'b1;
        cyc();
        clear = 1'b0; stop = 1'b0; start = 1'b0;
        check("prio_state", st0, S_IDLE);
        check("prio_total", tot0, 0);
        cyc();
        check("prio_flushed", tot0[15:0], 0);

        // Reset in the middle of a window.
        pulse_start();
        repeat (50) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("rst_total", tot0, 0);
        check("rst_ovf", ovf1, 0);
        npulse = 0;
        repeat (60) begin
            cyc();
            if (wv0) npulse++;
        end
        check("rst_no_pulse", npulse, 0);

        // Randomised traffic and control.
        idle_inputs();
        for (int n = 0; n < 3000; n++) begin
            tvalid = 2'($urandom);
            tready = 2'($urandom);
            tkeep  = {rand_keep(), rand_keep()};
            start  = ($urandom_range(0, 9) == 0);
            stop   = ($urandom_range(0, 39) == 0);
            clear  = ($urandom_range(0, 299) == 0);
            reset  = ($urandom_range(0, 999) == 0);
            cyc();
        end
        idle_inputs();
        reset = 1'b0;
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule

// File: doc/eth_axis_rate_monitor.md
# eth_axis_rate_monitor

Parametrised multi-channel AXI4-Stream throughput monitor for the 10G TCP/IP datapath. It snoops the user-side TX/RX streams between the TCP core and user logic, counts accepted bytes from `tkeep` per channel, and counts run cycles. It publishes fixed-window byte snapshots for on-chip debug and VIO readout. It generalises the ad-hoc single-channel RX byte/cycle counters: any channel count and width, explicit start/stop/clear, windowed rates, saturation, and `tkeep` checking.

## Interface
Parameters:
- `DATA_W`, 64, stream data width (multiple of 8); `KEEP_W` = `DATA_W/8`
- `NUM_CH`, 2, monitored streams (ch0 = TX user, ch1 = RX user)
- `CNT_W`, 48, width of every byte/cycle counter
- `WINDOW_CYCLES`, 156250000, window length in RUN cycles (1 s at 156.25 MHz); must be ≥ 2

Ports:
- `coreclk_out` in 1: clock
- `reset` in 1: reset, synchronous, active-high
- `mon_tvalid` in `NUM_CH`: snooped `tvalid`, one bit per channel
- `mon_tready` in `NUM_CH`: snooped `tready`
- `mon_tkeep` in `NUM_CH*KEEP_W`: snooped `tkeep`; channel c is at `[c*KEEP_W +: KEEP_W]`
- `start` in 1: arm the measurement
- `stop` in 1: freeze counting
- `clear` in 1: zero all counters and flags, go to IDLE
- `state_out` out 2: current FSM state
- `total_bytes` out `NUM_CH*CNT_W`: cumulative bytes per channel
- `total_cycles` out `CNT_W`: RUN cycles elapsed
- `win_bytes` out `NUM_CH*CNT_W`: bytes in the last completed window
- `win_valid` out 1: one-cycle pulse when `win_bytes` updates
- `keep_err` out `NUM_CH`: sticky flag, non-contiguous `tkeep` seen
- `ovf` out `NUM_CH+1`: sticky saturation flags (bit `NUM_CH` = cycle counter)

## Operation
- Beat on channel c: `mon_tvalid[c] & mon_tready[c]`. Addend = popcount of that channel's `tkeep`, range 0..`KEEP_W`, any pattern.
- Contiguous `tkeep`: `2^k-1`. Any other nonzero value during a beat sets `keep_err[c]`, and its bytes are still counted.
- FSM (encoding 0..3):
  - IDLE → ARMED on `start`.
  - ARMED → RUN on the first cycle any channel has a beat. That beat is counted.
  - RUN → HOLD on `stop`.
  - HOLD → ARMED on `start`. Counters are kept, so totals resume.
  - Any state → IDLE on `clear`.
- Priority: `reset` > `clear` > `stop` > `start`.
- Counting happens only in RUN, including the cycle of the ARMED→RUN transition. `total_cycles` increments once per RUN cycle.
- Window counter counts RUN cycles from 0 to `WINDOW_CYCLES-1`. On its last cycle, the window accumulator (including that cycle's addend) is copied to `win_bytes`, and the accumulator restarts from 0. On stop, the window count pauses.
- All counters saturate at all-ones and set the matching `ovf` bit; they never wrap.

## Timing
- Two-stage pipeline:
  - Stage 1 registers the beat qualifier and popcount per channel.
  - Stage 2 accumulates into the counters.
  - A beat at cycle t is visible on `total_bytes` at t+2.
- `win_valid` is high at t+2 for a window closing at t. `win_bytes` is stable from then until the next pulse.
- The stage-1 gate uses the current-cycle state. A beat in the same cycle as `stop` is counted.
- The monitor is passive: it never drives `tready`, and it imposes no handshake on the snooped streams.
- Reset and `clear`, effective the next edge:
  - `state_out`=0 (IDLE).
  - All counters, `win_bytes`, `win_valid`, `keep_err`, `ovf` = 0.
  - Pipeline registers are flushed, so an in-flight beat is discarded.

## Configuration
- `RATE_MON_PEAK_EN` defined: adds output `peak_win_bytes` (`NUM_CH*CNT_W`). It holds the maximum `win_bytes` per channel, updates on the same edge as `win_valid`, and is zeroed by reset/`clear`.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package `eth_mon_pkg`:
  - state constants IDLE/ARMED/RUN/HOLD
  - popcount and keep-contiguity functions
  - the default `WINDOW_CYCLES` constant
- One sub-module, `eth_sat_counter`: a `CNT_W` saturating accumulator with clear, enable, addend, and overflow-flag outputs. It is instantiated per byte counter, for the window accumulators, and for the cycle counter.

## Test plan
- **Steady rate:** `NUM_CH`=2, `WINDOW_CYCLES`=100. After `start`, ch0 has a full-`tkeep` beat every cycle → every `win_valid` shows ch0 `win_bytes`=800 and ch1=0.
- **Partial keep:** after `start`, beats with `tkeep`=0x01, 0x07, 0xFF → `total_bytes` ch0=12, first visible 2 cycles after the last beat; `keep_err`=0.
- **Bad keep:** one beat with `tkeep`=0x05 → counted as 2 bytes; `keep_err[0]`=1 until `clear`.
- **Arm/stop/resume:**
  - `start` with no traffic for 50 cycles → `total_cycles`=0 and state stays ARMED.
  - First beat → RUN.
  - `stop` → HOLD; counters are frozen while beats continue.
  - `start` → ARMED; totals are preserved.
- **Saturation:** `CNT_W`=8, 40 full beats → `total_bytes` ch0=255 and `ovf[0]`=1.
- **Priority/reset:**
  - `clear`, `stop` and `start` in the same cycle → IDLE with everything zero.
  - `reset` mid-window → all outputs zero and no `win_valid` pulse.
